imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_word_assembler.sv | 48 ++++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and byte width for the instruction memory loader
package imem_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs little-endian bytes into N-bit words
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int N     = 32,
    parameter int IDX_W = ((N / BYTE_W) > 1) ? $clog2(N / BYTE_W) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [N-1:0]      word_data,
    output logic              word_complete
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N / BYTE_W - 1);

    logic [N-1:0]     word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // word_data already carries the current byte so the top can latch a full word on the last byte
    always_comb begin
        word_data = word_q;
        word_data[int'(idx_q) * BYTE_W +: BYTE_W] = byte_data;
        word_complete = byte_valid && (idx_q == LAST_IDX);
        word_d = word_q;
        idx_d  = idx_q;
        if (clear || word_complete) begin
            word_d = '0;
            idx_d  = '0;
        end else if (byte_valid) begin
            word_d = word_data;
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader for the writable instruction memory with length and XOR checksum
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [N-1:0]      wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    localparam logic [16:0]     DEPTH = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   len_lo_q, len_lo_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [N-1:0]        wr_data_q, wr_data_d;

    logic                hs;
    logic                start_ok;
    logic                asm_valid;
    logic                word_complete;
    logic [N-1:0]        asm_word;
    logic [15:0]         len_full;
    logic [ADDR_W:0]     word_cnt_inc;

    assign in_ready     = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                          (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign busy         = in_ready;
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERROR);
    assign cpu_hold     = busy || error;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

    assign hs           = in_valid && in_ready;
    assign start_ok     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                    (state_q == ST_ERROR));
    assign asm_valid    = hs && (state_q == ST_DATA);
    assign len_full     = {in_data, len_lo_q};
    assign word_cnt_inc = word_cnt_q + ONE;

    word_assembler #(.N(N)) u_word_assembler (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_ok),
        .byte_valid    (asm_valid),
        .byte_data     (in_data),
        .word_data     (asm_word),
        .word_complete (word_complete)
    );

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d    = ST_LEN_LO;
                    len_lo_d   = '0;
                    len_d      = '0;
                    word_cnt_d = '0;
                    csum_d     = '0;
                end
            end
            ST_LEN_LO: begin
                if (hs) begin
                    len_lo_d = in_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (hs) begin
                    // the length never reaches the checksum; oversized loads abort before any write
                    if ({1'b0, len_full} > DEPTH) begin
                        state_d = ST_ERROR;
                    end else begin
                        len_d   = len_full[ADDR_W:0];
                        state_d = (len_full == 16'd0) ? ST_CHECK : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (hs) begin
                    csum_d = csum_q ^ in_data;
                    if (word_complete) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                        wr_data_d  = asm_word;
                        word_cnt_d = word_cnt_inc;
                        if (word_cnt_inc == len_q) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (hs) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // reset also drops a write that was due on the next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            csum_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    localparam int N      = 32;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [N-1:0]      wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_hold;

    imem_loader #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
    } wr_t;

    int         passed = 0;
    int         total  = 0;
    logic [7:0] stim[$];
    wr_t        exp_q[$];
    int         consumed;
    bit         exp_done;
    logic [7:0] model_cs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic put(input logic [7:0] v);
        stim.push_back(v);
    endtask

    // Stream semantics: length, little-endian words to consecutive addresses, XOR of data bytes
    function automatic void model();
        int         len;
        logic [7:0] cs;
        logic [31:0] w;
        wr_t        e;
        len = int'(stim[0]) | (int'(stim[1]) << 8);
        cs  = 8'h00;
        if (len > DEPTH) begin
            consumed = 2;
            exp_done = 1'b0;
            model_cs = cs;
            return;
        end
        for (int k = 0; k < len; k++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                w[8*j +: 8] = stim[2 + 4*k + j];
                cs = cs ^ stim[2 + 4*k + j];
            end
            e.addr = ADDR_W'(k);
            e.data = w;
            exp_q.push_back(e);
        end
        consumed = 3 + 4 * len;
        exp_done = (stim[consumed-1] == cs);
        model_cs = cs;
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_en", {25'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {25'd0, wr_addr}, {25'd0, e.addr});
                chk("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        chk("in_ready_accepting", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        start    = with_start;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_session(input int gap, input int start_at, input string tag);
        model();
        pulse_start();
        chk({tag, ":busy_after_start"}, {31'd0, busy}, 32'd1);
        chk({tag, ":done_cleared"}, {31'd0, done}, 32'd0);
        chk({tag, ":error_cleared"}, {31'd0, error}, 32'd0);
        for (int i = 0; i < consumed; i++) send_byte(stim[i], gap, (i == start_at));
        @(negedge clk);
        chk({tag, ":done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, ":error"}, {31'd0, error}, {31'd0, !exp_done});
        chk({tag, ":busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ":in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, ":cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
        chk({tag, ":writes_pending"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ":in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, ":wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, ":wr_addr"}, {25'd0, wr_addr}, 32'd0);
        chk({tag, ":wr_data"}, wr_data, 32'd0);
        chk({tag, ":busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ":done"}, {31'd0, done}, 32'd0);
        chk({tag, ":error"}, {31'd0, error}, 32'd0);
        chk({tag, ":cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    endtask

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("reset");

        stim.delete();
        put(8'h01); put(8'h00); put(8'h01); put(8'h00); put(8'h00); put(8'hF8); put(8'hF9);
        model();
        chk("pin_single_word", exp_q[0].data, 32'hF8000001);
        exp_q.delete();
        run_session(0, -1, "one_word");

        stim.delete();
        put(8'h00); put(8'h00); put(8'h00);
        run_session(0, -1, "empty_ok");

        stim.delete();
        put(8'h00); put(8'h00); put(8'h5A);
        model();
        chk("pin_empty_bad_sum", {31'd0, exp_done}, 32'd0);
        exp_q.delete();
        run_session(0, -1, "empty_bad_sum");

        stim.delete();
        put(8'h81); put(8'h00);
        run_session(0, -1, "len_129");

        stim.delete();
        put(8'h02); put(8'h00);
        put(8'h02); put(8'h80); put(8'h00); put(8'hF8);
        put(8'h83); put(8'h00); put(8'h05); put(8'h8B);
        put(8'h77);
        model();
        chk("pin_two_word_sum", {24'd0, model_cs}, 32'h77);
        exp_q.delete();
        run_session(1, -1, "two_word_gaps");

        pulse_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        chk("mid_reset:no_wr_en", {31'd0, wr_en}, 32'd0);

        stim.delete();
        put(8'h01); put(8'h00); put(8'h01); put(8'h00); put(8'h00); put(8'hF8); put(8'hF9);
        run_session(0, -1, "after_reset");

        stim.delete();
        put(8'h02); put(8'h00);
        put(8'h02); put(8'h80); put(8'h00); put(8'hF8);
        put(8'h83); put(8'h00); put(8'h05); put(8'h8B);
        put(8'h77);
        run_session(0, 4, "start_while_busy");

        stim.delete();
        put(8'h01); put(8'h00); put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF); put(8'h00);
        run_session(0, -1, "bad_sum_keeps_write");

        stim.delete();
        put(8'h80); put(8'h00);
        cs = 8'h00;
        for (int k = 0; k < DEPTH; k++) begin
            w = (32'h9E3779B9 * (k + 1)) ^ k;
            for (int j = 0; j < 4; j++) begin
                put(w[8*j +: 8]);
                cs = cs ^ w[8*j +: 8];
            end
        end
        put(cs);
        run_session(0, -1, "full_depth");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
